// File: rtl/xbox_mseq_pkg.sv
// Shared types and field positions for the XBOX accelerator-port line sequencer.
package xbox_mseq_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_FILL = 2'd1,
      OP_COPY = 2'd2,
      OP_ILL  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL_WR = 3'd1,
      ST_CP_RD   = 3'd2,
      ST_CP_WAIT = 3'd3,
      ST_CP_WR   = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   // CMD register fields
   localparam int CMD_OP_LSB  = 0;
   localparam int CMD_OP_W    = 2;
   localparam int CMD_LEN_LSB = 4;
   localparam int CMD_LEN_W   = 8;
   localparam int CMD_SRC_LSB = 12;
   localparam int CMD_DST_LSB = 20;
   localparam int CMD_MEM_W   = 8;
   localparam int CMD_ARM_BIT = 31;

   // ADDR register fields
   localparam int ADDR_SRC_LSB = 0;
   localparam int ADDR_DST_LSB = 16;

   // STATUS register fields
   localparam int STS_BUSY    = 0;
   localparam int STS_DONE    = 1;
   localparam int STS_ERR     = 2;
   localparam int STS_OVR     = 3;
   localparam int STS_ARMED   = 4;
   localparam int STS_REM_LSB = 8;

   // Memory line geometry
   localparam int LINE_WORDS = 8;
   localparam int LINE_BITS  = 32 * LINE_WORDS;
   localparam int BE_BITS    = LINE_BITS / 8;

endpackage

// File: rtl/xbox_xlr_mem_seq.sv
// Host-programmed line sequencer on the XBOX xlr memory port: FILL a pattern into N lines
// or COPY N lines between memory instances, reporting busy/done/err/ovr in STATUS.
// Optional build macro XBOX_MSEQ_TRIG_EN: CMD[31] arms the block instead of starting it,
// and a SOC xmem write to the address held in host reg CMD_REG+3 then launches the command.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_IDLE    | waiting for a CMD write (or armed trigger)
//  ST_FILL_WR | writing pattern to dst line, one line per cycle
//  ST_CP_RD   | read strobe to src line
//  ST_CP_WAIT | read data returning from src instance
//  ST_CP_WR   | write captured line to dst line
//  ST_DONE    | one cycle, raises sticky done
module xbox_xlr_mem_seq
   import xbox_mseq_pkg::*;
#(
   parameter int NUM_MEMS           = 1,
   parameter int LOG2_LINES_PER_MEM = 4,
   parameter int CMD_REG            = 0,
   parameter int STS_REG            = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   output logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
   output logic [NUM_MEMS*LINE_BITS-1:0]           xlr_mem_wdata,
   output logic [NUM_MEMS*BE_BITS-1:0]             xlr_mem_be,
   output logic [NUM_MEMS-1:0]                     xlr_mem_rd,
   output logic [NUM_MEMS-1:0]                     xlr_mem_wr,
   input  logic [NUM_MEMS*LINE_BITS-1:0]           xlr_mem_rdata,
   input  logic [32*32-1:0]                        host_regs,
   input  logic [31:0]                             host_regs_valid_pulse,
   output logic [32*32-1:0]                        host_regs_data_out,
   output logic [31:0]                             host_regs_valid_out,
   input  logic [18:0]                             trig_soc_xmem_wr_addr,
   input  logic                                    trig_soc_xmem_wr
);

   localparam int LW = LOG2_LINES_PER_MEM;

   state_e                   state_q, state_d;
   logic [CMD_MEM_W-1:0]     src_mem_q, src_mem_d;
   logic [CMD_MEM_W-1:0]     dst_mem_q, dst_mem_d;
   logic [LW-1:0]            src_line_q, src_line_d;
   logic [LW-1:0]            dst_line_q, dst_line_d;
   logic [CMD_LEN_W-1:0]     rem_q, rem_d;
   logic [31:0]              pat_q, pat_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     ovr_q, ovr_d;
   logic                     armed_q, armed_d;

   logic [NUM_MEMS*LW-1:0]        addr_d;
   logic [NUM_MEMS*LINE_BITS-1:0] wdata_d;
   logic [NUM_MEMS*BE_BITS-1:0]   be_d;
   logic [NUM_MEMS-1:0]           rd_d;
   logic [NUM_MEMS-1:0]           wr_d;

   logic [31:0]              cmd_w, addr_w, pat_w;
   op_e                      op_w;
   logic [CMD_LEN_W-1:0]     len_w;
   logic [CMD_MEM_W-1:0]     src_mem_w, dst_mem_w;
   logic                     src_bad, dst_bad;
   logic                     cmd_pulse, start_req, arm_req;
   logic                     busy;
   logic [LINE_BITS-1:0]     rdata_src;
   logic [31:0]              status;
   logic                     unused_in;

   assign cmd_w     = host_regs[CMD_REG*32 +: 32];
   assign addr_w    = host_regs[(CMD_REG+1)*32 +: 32];
   assign pat_w     = host_regs[(CMD_REG+2)*32 +: 32];
   assign op_w      = op_e'(cmd_w[CMD_OP_LSB +: CMD_OP_W]);
   assign len_w     = cmd_w[CMD_LEN_LSB +: CMD_LEN_W];
   assign src_mem_w = cmd_w[CMD_SRC_LSB +: CMD_MEM_W];
   assign dst_mem_w = cmd_w[CMD_DST_LSB +: CMD_MEM_W];
   assign src_bad   = ({24'd0, src_mem_w} >= 32'(NUM_MEMS));
   assign dst_bad   = ({24'd0, dst_mem_w} >= 32'(NUM_MEMS));
   assign cmd_pulse = host_regs_valid_pulse[CMD_REG];
   assign busy      = !(state_q inside {ST_IDLE, ST_DONE});

`ifdef XBOX_MSEQ_TRIG_EN
   logic trig_hit;
   assign trig_hit  = armed_q && trig_soc_xmem_wr &&
                      (trig_soc_xmem_wr_addr == host_regs[(CMD_REG+3)*32 +: 19]);
   assign arm_req   = cmd_pulse && cmd_w[CMD_ARM_BIT];
   assign start_req = (cmd_pulse && !cmd_w[CMD_ARM_BIT]) || trig_hit;
`else
   assign arm_req   = 1'b0;
   assign start_req = cmd_pulse;
`endif

   // Input bits that carry no function in this configuration (reserved fields, other regs).
   assign unused_in = ^{host_regs, host_regs_valid_pulse, trig_soc_xmem_wr_addr, trig_soc_xmem_wr};

   // State, counters, latched command and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         src_mem_q  <= '0;
         dst_mem_q  <= '0;
         src_line_q <= '0;
         dst_line_q <= '0;
         rem_q      <= '0;
         pat_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_mem_q  <= src_mem_d;
         dst_mem_q  <= dst_mem_d;
         src_line_q <= src_line_d;
         dst_line_q <= dst_line_d;
         rem_q      <= rem_d;
         pat_q      <= pat_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
         armed_q    <= armed_d;
      end
   end

   // Next-state: command validation at start, per-line address/length stepping.
   always_comb begin
      state_d    = state_q;
      src_mem_d  = src_mem_q;
      dst_mem_d  = dst_mem_q;
      src_line_d = src_line_q;
      dst_line_d = dst_line_q;
      rem_d      = rem_q;
      pat_d      = pat_q;
      done_d     = done_q;
      err_d      = err_q;
      ovr_d      = ovr_q;
      armed_d    = armed_q;

      if (cmd_pulse && busy)
         ovr_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               armed_d    = 1'b0;
               src_mem_d  = src_mem_w;
               dst_mem_d  = dst_mem_w;
               src_line_d = addr_w[ADDR_SRC_LSB +: LW];
               dst_line_d = addr_w[ADDR_DST_LSB +: LW];
               pat_d      = pat_w;
               rem_d      = '0;
               if (op_w == OP_ILL || dst_bad || (op_w == OP_COPY && src_bad)) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (op_w == OP_NOP || len_w == '0) begin
                  state_d = ST_DONE;
               end else begin
                  rem_d   = len_w;
                  state_d = (op_w == OP_FILL) ? ST_FILL_WR : ST_CP_RD;
               end
            end else if (arm_req) begin
               armed_d = 1'b1;
            end
         end
         ST_FILL_WR: begin
            rem_d      = rem_q - 1'b1;
            dst_line_d = dst_line_q + 1'b1;
            if (rem_q == 8'd1)
               state_d = ST_DONE;
         end
         ST_CP_RD:   state_d = ST_CP_WAIT;
         ST_CP_WAIT: state_d = ST_CP_WR;
         ST_CP_WR: begin
            rem_d      = rem_q - 1'b1;
            src_line_d = src_line_q + 1'b1;
            dst_line_d = dst_line_q + 1'b1;
            state_d    = (rem_q == 8'd1) ? ST_DONE : ST_CP_RD;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Select the read line returned by the source instance.
   always_comb begin
      rdata_src = '0;
      for (int m = 0; m < NUM_MEMS; m++)
         if (src_mem_q == CMD_MEM_W'(m))
            rdata_src = xlr_mem_rdata[m*LINE_BITS +: LINE_BITS];
   end

   // Memory-port values for the upcoming state, so the registered strobes line up with the state.
   // The copy line buffer is the wdata register itself, loaded as CP_WAIT hands over to CP_WR.
   always_comb begin
      addr_d  = '0;
      wdata_d = '0;
      be_d    = '0;
      rd_d    = '0;
      wr_d    = '0;
      for (int m = 0; m < NUM_MEMS; m++) begin
         if ((state_d == ST_FILL_WR || state_d == ST_CP_WR) && dst_mem_d == CMD_MEM_W'(m)) begin
            addr_d[m*LW +: LW]                = dst_line_d;
            wdata_d[m*LINE_BITS +: LINE_BITS] = (state_d == ST_FILL_WR) ? {LINE_WORDS{pat_d}}
                                                                        : rdata_src;
            be_d[m*BE_BITS +: BE_BITS]        = '1;
            wr_d[m]                           = 1'b1;
         end else if (state_d == ST_CP_RD && src_mem_d == CMD_MEM_W'(m)) begin
            addr_d[m*LW +: LW] = src_line_d;
            rd_d[m]            = 1'b1;
         end
      end
   end

   // Registered memory-port outputs; reset drops strobes immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xlr_mem_addr  <= '0;
         xlr_mem_wdata <= '0;
         xlr_mem_be    <= '0;
         xlr_mem_rd    <= '0;
         xlr_mem_wr    <= '0;
      end else begin
         xlr_mem_addr  <= addr_d;
         xlr_mem_wdata <= wdata_d;
         xlr_mem_be    <= be_d;
         xlr_mem_rd    <= rd_d;
         xlr_mem_wr    <= wr_d;
      end
   end

   // STATUS word assembled from state and sticky flags.
   always_comb begin
      status                           = '0;
      status[STS_BUSY]                 = busy;
      status[STS_DONE]                 = done_q;
      status[STS_ERR]                  = err_q;
      status[STS_OVR]                  = ovr_q;
      status[STS_ARMED]                = armed_q;
      status[STS_REM_LSB +: CMD_LEN_W] = rem_q;
   end

   // Read-back bus: only the STATUS slot is driven.
   always_comb begin
      host_regs_data_out                   = '0;
      host_regs_data_out[STS_REG*32 +: 32] = status;
      host_regs_valid_out                  = '0;
      host_regs_valid_out[STS_REG]         = 1'b1;
   end

endmodule
